// File: rtl/fetch_fd_stage.sv
// F-stage program counter, next-PC selection and F/D pipeline register for the
// five-stage MIPS core; control transfers resolve in D with one delay slot.
module fetch_fd_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [2:0]  NPCType,
  input  logic        CMPResult,
  input  logic [31:0] D_RSData,
  input  logic [31:0] F_instr,
  output logic [31:0] F_PC,
  output logic [31:0] D_instr,
  output logic [31:0] D_PC,
  output logic [31:0] D_PC8,
  output logic        D_valid,
  output logic        F_misalign
);

  localparam logic [31:0] IM_LAST = IM_BASE + (32'(IM_WORDS) << 2) - 32'd4;

  localparam logic [2:0] NPC_SEQ = 3'd0;
  localparam logic [2:0] NPC_BEQ = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic [31:0] f_pc_r;
  logic [31:0] d_instr_r;
  logic [31:0] d_pc_r;
  logic        d_valid_r;
  logic [31:0] pc_plus4_s;
  logic [31:0] npc_s;
  logic        fetch_ok_s;

  function automatic logic fetch_ok(input logic [31:0] addr);
    fetch_ok = (addr[1:0] == 2'b00) && (addr >= IM_BASE) && (addr <= IM_LAST);
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [15:0] imm);
    branch_target = pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                              input logic [25:0] idx);
    jump_target = {pc[31:28], idx, 2'b00};
  endfunction

  assign pc_plus4_s = f_pc_r + 32'd4;
  assign fetch_ok_s = fetch_ok(f_pc_r);

  // Next-PC select; branch and jump targets are relative to the instruction in D
  always_comb begin
    npc_s = pc_plus4_s;
    case (NPCType)
      NPC_SEQ: npc_s = pc_plus4_s;
      NPC_BEQ: begin
        if (CMPResult) begin
          npc_s = branch_target(d_pc_r, d_instr_r[15:0]);
        end else begin
          npc_s = pc_plus4_s;
        end
      end
      NPC_J:   npc_s = jump_target(d_pc_r, d_instr_r[25:0]);
      NPC_JR:  npc_s = D_RSData;
      default: npc_s = pc_plus4_s;
    endcase
  end

  // PC and F/D register; a stall freezes both so a pending transfer re-evaluates
  always_ff @(posedge clk) begin
    if (!reset) begin
      f_pc_r    <= PC_RESET;
      d_instr_r <= NOP;
      d_pc_r    <= PC_RESET;
      d_valid_r <= 1'b0;
    end else if (!Stall) begin
      f_pc_r    <= npc_s;
      d_instr_r <= fetch_ok_s ? F_instr : NOP;
      d_pc_r    <= f_pc_r;
      d_valid_r <= fetch_ok_s;
    end
  end

  assign F_PC       = f_pc_r;
  assign D_instr    = d_instr_r;
  assign D_PC       = d_pc_r;
  assign D_PC8      = d_pc_r + 32'd8;
  assign D_valid    = d_valid_r;
  assign F_misalign = !fetch_ok_s;

endmodule

// File: tb/tb_fetch_fd_stage.sv
// Bench for fetch_fd_stage: directed test-plan steps then randomized cycles,
// every cycle compared against a cycle-level reference model of the F/D stage.
module tb_fetch_fd_stage;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int unsigned IM_WORDS = 4096;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic [2:0]  NPCType;
  logic        CMPResult;
  logic [31:0] D_RSData;
  logic [31:0] F_instr;
  logic [31:0] F_PC;
  logic [31:0] D_instr;
  logic [31:0] D_PC;
  logic [31:0] D_PC8;
  logic        D_valid;
  logic        F_misalign;

  fetch_fd_stage #(.PC_RESET(PC_RESET), .IM_BASE(IM_BASE), .IM_WORDS(IM_WORDS)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .NPCType(NPCType),
    .CMPResult(CMPResult), .D_RSData(D_RSData), .F_instr(F_instr),
    .F_PC(F_PC), .D_instr(D_instr), .D_PC(D_PC), .D_PC8(D_PC8),
    .D_valid(D_valid), .F_misalign(F_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:IM_WORDS-1];
  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_fpc = 32'h0;
  logic [31:0] m_dinstr = 32'h0;
  logic [31:0] m_dpc = 32'h0;
  logic        m_dvalid = 1'b0;

  function automatic logic legal(input logic [31:0] a);
    return (a % 32'd4 == 32'd0) && (a >= IM_BASE) && (a <= IM_BASE + 32'(4 * IM_WORDS) - 32'd4);
  endfunction

  function automatic logic [31:0] imem_rd(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - IM_BASE) / 32'd4;
    if (a >= IM_BASE && idx < 32'(IM_WORDS)) return mem[idx];
    return 32'hDEAD_BEEF ^ a;
  endfunction

  function automatic void imem_wr(input logic [31:0] a, input logic [31:0] d);
    mem[(a - IM_BASE) / 32'd4] = d;
  endfunction

  function automatic logic [31:0] ref_npc(input logic [2:0] nt, input logic cmp,
                                          input logic [31:0] rs);
    logic signed [31:0] off;
    off = 32'($signed(m_dinstr[15:0]));
    case (nt)
      3'd1:    return cmp ? m_dpc + 32'd4 + 32'(off * 4) : m_fpc + 32'd4;
      3'd2:    return (m_dpc & 32'hF000_0000) | ((m_dinstr & 32'h03FF_FFFF) << 2);
      3'd3:    return rs;
      default: return m_fpc + 32'd4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("F_PC", F_PC, m_fpc);
    chk("D_instr", D_instr, m_dinstr);
    chk("D_PC", D_PC, m_dpc);
    chk("D_PC8", D_PC8, m_dpc + 32'd8);
    chk("D_valid", {31'd0, D_valid}, {31'd0, m_dvalid});
    chk("F_misalign", {31'd0, F_misalign}, {31'd0, !legal(m_fpc)});
  endtask

  // one clock: drive inputs, advance the model, then compare after the edge
  task automatic cycle(input logic rst, input logic stl, input logic [2:0] nt,
                       input logic cmp, input logic [31:0] rs);
    logic [31:0] n_fpc;
    reset = rst; Stall = stl; NPCType = nt; CMPResult = cmp; D_RSData = rs;
    F_instr = imem_rd(F_PC);
    n_fpc = ref_npc(nt, cmp, rs);
    @(posedge clk);
    if (!rst) begin
      m_fpc = PC_RESET; m_dinstr = 32'h0; m_dpc = PC_RESET; m_dvalid = 1'b0;
    end else if (!stl) begin
      m_dinstr = legal(m_fpc) ? imem_rd(m_fpc) : 32'h0;
      m_dvalid = legal(m_fpc);
      m_dpc = m_fpc;
      m_fpc = n_fpc;
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] rs;
    reset = 1'b0; Stall = 1'b0; NPCType = 3'd0; CMPResult = 1'b0;
    D_RSData = 32'h0; F_instr = 32'h0;
    for (int i = 0; i < int'(IM_WORDS); i++) mem[i] = $urandom;
    imem_wr(32'h0000_3000, 32'h3421_0001);
    imem_wr(32'h0000_3010, 32'h1000_FFFF);
    imem_wr(32'h0000_3020, 32'h0C00_0C10);
    imem_wr(32'h0000_3040, 32'h1000_0004);

    // reset held two cycles
    cycle(1'b0, 1'b0, 3'd0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 3'd0, 1'b0, 32'h0);
    chk("rst_fpc", F_PC, 32'h0000_3000);
    chk("rst_dinstr", D_instr, 32'h0);
    chk("rst_dvalid", {31'd0, D_valid}, 32'd0);

    // first fetch
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 32'h0);
    chk("seq_dinstr", D_instr, 32'h3421_0001);
    chk("seq_dpc", D_PC, 32'h0000_3000);
    chk("seq_dpc8", D_PC8, 32'h0000_3008);
    chk("seq_fpc", F_PC, 32'h0000_3004);

    // beq taken with imm=-1
    repeat (4) cycle(1'b1, 1'b0, 3'd0, 1'b0, 32'h0);
    chk("beq_in_d", D_PC, 32'h0000_3010);
    cycle(1'b1, 1'b0, 3'd1, 1'b1, 32'h0);
    chk("beq_taken", F_PC, 32'h0000_3010);
    // beq again, not taken
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 3'd1, 1'b0, 32'h0);
    chk("beq_not_taken", F_PC, 32'h0000_3018);

    // jal then jr
    repeat (3) cycle(1'b1, 1'b0, 3'd0, 1'b0, 32'h0);
    chk("jal_in_d", D_PC, 32'h0000_3020);
    cycle(1'b1, 1'b0, 3'd2, 1'b0, 32'h0);
    chk("jal_target", F_PC, 32'h0000_3040);
    chk("jal_slot", D_PC, 32'h0000_3024);
    cycle(1'b1, 1'b0, 3'd3, 1'b0, 32'h0000_3100);
    chk("jr_target", F_PC, 32'h0000_3100);

    // stall with taken beq (beq +4 at 0x3040) in D
    repeat (3) begin
      cycle(1'b1, 1'b1, 3'd1, 1'b1, 32'h0);
      chk("stall_fpc", F_PC, 32'h0000_3100);
      chk("stall_dpc", D_PC, 32'h0000_3040);
    end
    cycle(1'b1, 1'b0, 3'd1, 1'b1, 32'h0);
    chk("stall_release", F_PC, 32'h0000_3054);
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 32'h0);
    chk("branch_once", F_PC, 32'h0000_3058);

    // misaligned jr target
    cycle(1'b1, 1'b0, 3'd3, 1'b0, 32'h0000_3002);
    chk("mis_flag", {31'd0, F_misalign}, 32'd1);
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 32'h0);
    chk("mis_nop", D_instr, 32'h0);
    chk("mis_dvalid", {31'd0, D_valid}, 32'd0);
    chk("mis_fpc", F_PC, 32'h0000_3006);

    // reset during stall with pending branch
    cycle(1'b0, 1'b1, 3'd1, 1'b1, 32'h0);
    chk("rst_in_stall", F_PC, 32'h0000_3000);

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    rs = IM_BASE + 32'(4 * $urandom_range(0, IM_WORDS - 1));
        2:       rs = IM_BASE + 32'(4 * $urandom_range(0, IM_WORDS - 1)) + 32'($urandom_range(1, 3));
        default: rs = $urandom;
      endcase
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
